// File: rtl/dm_bus_unit.sv
// dm_bus_unit: data-memory load/store unit. Checks each access against the
// data-memory range and the timer windows, steers byte lanes onto a
// word-wide bus, waits (bounded) for bus_ack and returns a one-cycle response.
//
// Request handshake: a request is taken on a rising clk edge where
// req_valid && req_ready; req_ready is high only while idle, and op/addr/data
// are captured on that edge so the requester may change them afterwards.
module dm_bus_unit #(
    parameter logic [31:0] DM_BASE   = 32'h0000_0000,
    parameter logic [31:0] DM_LIMIT  = 32'h0000_2FFF,
    parameter int          NUM_TC    = 2,
    parameter logic [31:0] TC_BASE0  = 32'h0000_7F00,
    parameter logic [3:0]  TC_RO_OFF = 4'h8,
    parameter int          TIMEOUT   = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_op,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_adel,
    output logic        rsp_ades,
    output logic        rsp_buserr,
    output logic [1:0]  dbgState
);

    localparam logic [2:0] OP_LW = 3'd0, OP_LH = 3'd1, OP_LHU = 3'd2, OP_LB = 3'd3;
    localparam logic [2:0] OP_LBU = 3'd4, OP_SW = 3'd5, OP_SH = 3'd6;

    typedef enum logic [1:0] {IDLE = 2'd0, BUS = 2'd1, RESP = 2'd2} stateE;

    stateE       state, nextState;
    logic [7:0]  cnt;
    logic [2:0]  opQ;
    logic [31:0] addrQ, wdataQ, rdataQ;
    logic [3:0]  beQ;
    logic        weQ, adelQ, adesQ, buserrQ;

    logic        reqIsLoad, reqIsWord, reqIsHalf, reqErr;
    logic        inDm, inTc, tcRo, misalign;
    logic [31:0] dmOff, tcOff, reqWdataLanes, laneData, loadData;
    logic [3:0]  reqBe;
    logic        lastCycle;

    assign lastCycle = (cnt == 8'(TIMEOUT - 1));
    assign dbgState  = state;

    // Decode the incoming request: legality, byte enables and lane-replicated store data.
    always_comb begin
        reqIsLoad = (req_op < OP_SW);
        reqIsWord = (req_op == OP_LW) || (req_op == OP_SW);
        reqIsHalf = (req_op == OP_LH) || (req_op == OP_LHU) || (req_op == OP_SH);
        dmOff     = req_addr - DM_BASE;
        inDm      = (dmOff <= (DM_LIMIT - DM_BASE));
        inTc      = 1'b0;
        tcRo      = 1'b0;
        tcOff     = '0;
        for (int k = 0; k < NUM_TC; k++) begin
            tcOff = req_addr - (TC_BASE0 + 32'(16 * k));
            if (tcOff[31:4] == 28'd0) begin
                inTc = 1'b1;
                if (tcOff[3:0] == TC_RO_OFF) tcRo = 1'b1;
            end
        end
        if (reqIsWord)      misalign = (req_addr[1:0] != 2'b00);
        else if (reqIsHalf) misalign = req_addr[0];
        else                misalign = 1'b0;
        reqErr = (!inDm && !inTc) || misalign || (inTc && !reqIsWord) || (!reqIsLoad && tcRo);
        if (reqIsWord) begin
            reqBe         = 4'b1111;
            reqWdataLanes = req_wdata;
        end else if (reqIsHalf) begin
            reqBe         = 4'b0011 << {req_addr[1], 1'b0};
            reqWdataLanes = {2{req_wdata[15:0]}};
        end else begin
            reqBe         = 4'b0001 << req_addr[1:0];
            reqWdataLanes = {4{req_wdata[7:0]}};
        end
        if (reqIsLoad) reqWdataLanes = '0;
    end

    // Pick the addressed lane out of the returned bus word and extend it.
    always_comb begin
        laneData = bus_rdata >> {addrQ[1:0], 3'b000};
        case (opQ)
            OP_LW:   loadData = bus_rdata;
            OP_LH:   loadData = {{16{laneData[15]}}, laneData[15:0]};
            OP_LHU:  loadData = {16'd0, laneData[15:0]};
            OP_LB:   loadData = {{24{laneData[7]}}, laneData[7:0]};
            OP_LBU:  loadData = {24'd0, laneData[7:0]};
            default: loadData = '0;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= nextState;
    end

    // Next-state logic: errors skip the bus, the bus phase ends on ack or timeout.
    always_comb begin
        nextState = state;
        case (state)
            IDLE: if (req_valid) nextState = reqErr ? RESP : BUS;
            BUS:  if (bus_ack || lastCycle) nextState = RESP;
            RESP: nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // Capture the request at acceptance, count bus cycles and latch the result.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt     <= '0;
            opQ     <= '0;
            addrQ   <= '0;
            wdataQ  <= '0;
            beQ     <= '0;
            weQ     <= 1'b0;
            adelQ   <= 1'b0;
            adesQ   <= 1'b0;
            buserrQ <= 1'b0;
            rdataQ  <= '0;
        end else begin
            case (state)
                IDLE: if (req_valid) begin
                    cnt     <= '0;
                    opQ     <= req_op;
                    addrQ   <= req_addr;
                    wdataQ  <= reqWdataLanes;
                    beQ     <= reqBe;
                    weQ     <= !reqIsLoad;
                    adelQ   <= reqErr && reqIsLoad;
                    adesQ   <= reqErr && !reqIsLoad;
                    buserrQ <= 1'b0;
                    rdataQ  <= '0;
                end
                BUS: begin
                    cnt <= cnt + 8'd1;
                    if (bus_ack) begin
                        rdataQ <= weQ ? 32'd0 : loadData;
                    end else if (lastCycle) begin
                        buserrQ <= 1'b1;
                        rdataQ  <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs: bus signals only while in BUS, response only while in RESP.
    always_comb begin
        req_ready  = (state == IDLE);
        bus_req    = (state == BUS);
        bus_we     = (state == BUS) && weQ;
        bus_addr   = (state == BUS) ? {addrQ[31:2], 2'b00} : 32'd0;
        bus_be     = (state == BUS) ? beQ : 4'd0;
        bus_wdata  = (state == BUS) ? wdataQ : 32'd0;
        rsp_valid  = (state == RESP);
        rsp_rdata  = (state == RESP) ? rdataQ : 32'd0;
        rsp_adel   = (state == RESP) && adelQ;
        rsp_ades   = (state == RESP) && adesQ;
        rsp_buserr = (state == RESP) && buserrQ;
    end

endmodule

// File: tb/tb_dm_bus_unit.sv
// tb_dm_bus_unit: directed checks of dm_bus_unit with hand-computed results.
module tb_dm_bus_unit;

    localparam logic [2:0] OP_LW = 3'd0, OP_LH = 3'd1, OP_LHU = 3'd2, OP_LB = 3'd3;
    localparam logic [2:0] OP_LBU = 3'd4, OP_SW = 3'd5, OP_SH = 3'd6, OP_SB = 3'd7;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_ready;
    logic [2:0]  req_op;
    logic [31:0] req_addr, req_wdata;
    logic        bus_req, bus_we, bus_ack;
    logic [31:0] bus_addr, bus_wdata, bus_rdata;
    logic [3:0]  bus_be;
    logic        rsp_valid, rsp_adel, rsp_ades, rsp_buserr;
    logic [31:0] rsp_rdata;
    logic [1:0]  dbgState;

    int checkCount = 0;
    int errorCount = 0;
    logic [31:0] expQ[$];

    dm_bus_unit dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
        .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_adel(rsp_adel),
        .rsp_ades(rsp_ades), .rsp_buserr(rsp_buserr), .dbgState(dbgState)
    );

    // Clock
    always #5 clk = ~clk;

    // Watchdog
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic checkEq(input string tag, input logic [31:0] obs, input logic [31:0] expV);
        checkCount++;
        if (obs !== expV) begin
            errorCount++;
            $display("FAIL %s: got %h expected %h", tag, obs, expV);
        end
    endtask

    // Present a request for one edge, then scramble the inputs to prove they are ignored.
    task automatic acceptReq(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wdata);
        req_valid = 1'b1;
        req_op    = op;
        req_addr  = addr;
        req_wdata = wdata;
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_op    = 3'd7;
        req_addr  = 32'hDEAD_BEEF;
        req_wdata = 32'hFFFF_FFFF;
    endtask

    task automatic runBus(input string name, input logic [2:0] op, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] rdata,
                          input logic [3:0] expBe, input logic [31:0] expWdata,
                          input logic [31:0] expRdata, input int ackDelay);
        expQ.push_back(expRdata);
        checkEq({name, " ready"}, req_ready, 1);
        acceptReq(op, addr, wdata);
        checkEq({name, " state"}, dbgState, 2'd1);
        for (int i = 0; i < ackDelay; i++) begin
            checkEq({name, " bus_req hold"}, bus_req, 1);
            @(posedge clk); #1;
        end
        checkEq({name, " bus_req"}, bus_req, 1);
        checkEq({name, " bus_we"}, bus_we, (op >= OP_SW));
        checkEq({name, " bus_addr"}, bus_addr, {addr[31:2], 2'b00});
        checkEq({name, " bus_be"}, bus_be, expBe);
        checkEq({name, " bus_wdata"}, bus_wdata, expWdata);
        bus_ack   = 1'b1;
        bus_rdata = rdata;
        @(posedge clk); #1;
        bus_ack   = 1'b0;
        bus_rdata = 32'h5A5A_5A5A;
        checkEq({name, " rsp_valid"}, rsp_valid, 1);
        checkEq({name, " bus_req off"}, bus_req, 0);
        checkEq({name, " flags"}, {rsp_adel, rsp_ades, rsp_buserr}, 3'b000);
        checkEq({name, " rsp_rdata"}, rsp_rdata, expQ.pop_front());
        @(posedge clk); #1;
        checkEq({name, " rsp_valid drop"}, rsp_valid, 0);
        checkEq({name, " ready again"}, req_ready, 1);
    endtask

    task automatic runErr(input string name, input logic [2:0] op, input logic [31:0] addr,
                          input logic expAdel, input logic expAdes);
        checkEq({name, " ready"}, req_ready, 1);
        acceptReq(op, addr, 32'h1234_5678);
        checkEq({name, " no bus_req"}, bus_req, 0);
        checkEq({name, " rsp_valid"}, rsp_valid, 1);
        checkEq({name, " flags"}, {rsp_adel, rsp_ades, rsp_buserr}, {expAdel, expAdes, 1'b0});
        checkEq({name, " rsp_rdata"}, rsp_rdata, 0);
        @(posedge clk); #1;
        checkEq({name, " rsp_valid drop"}, rsp_valid, 0);
        checkEq({name, " flags drop"}, {rsp_adel, rsp_ades}, 2'b00);
    endtask

    initial begin
        int cycles;
        reset = 1'b1;
        req_valid = 1'b0; req_op = '0; req_addr = '0; req_wdata = '0;
        bus_ack = 1'b0; bus_rdata = '0;
        #12;
        checkEq("reset req_ready", req_ready, 1);
        checkEq("reset bus_req", bus_req, 0);
        checkEq("reset bus_be", bus_be, 0);
        checkEq("reset rsp_valid", rsp_valid, 0);
        checkEq("reset state", dbgState, 0);
        reset = 1'b0;
        @(posedge clk); #1;

        runBus("LB 13", OP_LB, 32'h0000_0013, 32'h0, 32'h80FF_1234, 4'b1000, 32'h0, 32'hFFFF_FF80, 0);
        runBus("SH 02", OP_SH, 32'h0000_0002, 32'h0000_BEEF, 32'hFFFF_FFFF, 4'b1100, 32'hBEEF_BEEF, 32'h0, 0);
        runBus("LW 100", OP_LW, 32'h0000_0100, 32'h0, 32'h1234_5678, 4'b1111, 32'h0, 32'h1234_5678, 3);
        runBus("LH 02", OP_LH, 32'h0000_0002, 32'h0, 32'h8001_0000, 4'b1100, 32'h0, 32'hFFFF_8001, 1);
        runBus("LBU 11", OP_LBU, 32'h0000_0011, 32'h0, 32'h0000_A500, 4'b0010, 32'h0, 32'h0000_00A5, 0);
        runBus("SB 2FFF", OP_SB, 32'h0000_2FFF, 32'h1234_5678, 32'h0, 4'b1000, 32'h7878_7878, 32'h0, 0);
        runBus("SW 7F04", OP_SW, 32'h0000_7F04, 32'hCAFE_F00D, 32'h0, 4'b1111, 32'hCAFE_F00D, 32'h0, 0);
        runBus("LW 7F18", OP_LW, 32'h0000_7F18, 32'h0, 32'h0BAD_CAFE, 4'b1111, 32'h0, 32'h0BAD_CAFE, 0);
        runBus("LW ack at timeout", OP_LW, 32'h0000_0200, 32'h0, 32'h0000_0042, 4'b1111, 32'h0, 32'h0000_0042, 15);

        runErr("LW 06 misaligned", OP_LW, 32'h0000_0006, 1'b1, 1'b0);
        runErr("SW 7F08 ro", OP_SW, 32'h0000_7F08, 1'b0, 1'b1);
        runErr("SB 7F14 timer", OP_SB, 32'h0000_7F14, 1'b0, 1'b1);
        runErr("LW 3000 range", OP_LW, 32'h0000_3000, 1'b1, 1'b0);
        runErr("LW 7F20 no window", OP_LW, 32'h0000_7F20, 1'b1, 1'b0);
        runErr("LHU 01 misaligned", OP_LHU, 32'h0000_0001, 1'b1, 1'b0);
        runErr("SH 03 misaligned", OP_SH, 32'h0000_0003, 1'b0, 1'b1);

        // bus_ack while idle must do nothing
        bus_ack = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        checkEq("idle ack ready", req_ready, 1);
        checkEq("idle ack rsp_valid", rsp_valid, 0);
        bus_ack = 1'b0;

        // timeout with ack withheld
        checkEq("timeout ready", req_ready, 1);
        acceptReq(OP_LW, 32'h0000_0100, 32'h0);
        cycles = 0;
        while (bus_req === 1'b1 && cycles < 40) begin
            cycles++;
            @(posedge clk); #1;
        end
        checkEq("timeout bus_req cycles", cycles, 16);
        checkEq("timeout rsp_valid", rsp_valid, 1);
        checkEq("timeout buserr", rsp_buserr, 1);
        checkEq("timeout adel/ades", {rsp_adel, rsp_ades}, 2'b00);
        checkEq("timeout rsp_rdata", rsp_rdata, 0);
        @(posedge clk); #1;
        checkEq("timeout rsp_valid drop", rsp_valid, 0);
        checkEq("timeout buserr drop", rsp_buserr, 0);

        // reset while in BUS
        acceptReq(OP_LW, 32'h0000_0100, 32'h0);
        checkEq("midreset bus_req before", bus_req, 1);
        #2 reset = 1'b1;
        #1;
        checkEq("midreset bus_req async", bus_req, 0);
        checkEq("midreset ready", req_ready, 1);
        #3 reset = 1'b0;
        @(posedge clk); #1;
        checkEq("postreset ready", req_ready, 1);
        checkEq("postreset rsp_valid", rsp_valid, 0);
        checkEq("postreset bus_req", bus_req, 0);
        runBus("LHU 02", OP_LHU, 32'h0000_0002, 32'h0, 32'h8001_0000, 4'b1100, 32'h0, 32'h0000_8001, 0);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
